// File: rtl/imm_alu_pkg.sv
// rtl/imm_alu_pkg.sv - shared types and constants for the immediate ALU sequencer
//
// Holds the sequencer state encoding, the immediate-format opcode values and
// the ALU operation codes driven on the ops bus.

package imm_alu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_DONE  = 4'd7,
        ST_FAULT = 4'd8
    } state_t;

    // Opcode field values, ir[31:27]
    localparam logic [4:0] OPC_ADDI = 5'b01000;
    localparam logic [4:0] OPC_ANDI = 5'b01001;
    localparam logic [4:0] OPC_ORI  = 5'b01010;

    // ALU operation codes
    localparam logic [4:0] OPS_ADD  = 5'b00011;
    localparam logic [4:0] OPS_AND  = 5'b01010;
    localparam logic [4:0] OPS_OR   = 5'b01011;

endpackage

// File: rtl/imm_op_decode.sv
// rtl/imm_op_decode.sv - combinational opcode to ALU ops decoder
//
// Ports:
//   opc   in   OPC_W  opcode field
//   legal out  1      opcode is a supported immediate ALU instruction
//   ops   out  OPS_W  ALU operation code (0 when illegal)

module imm_op_decode
    import imm_alu_pkg::*;
#(
    parameter int OPC_W = 5,
    parameter int OPS_W = 5
) (
    input  logic [OPC_W-1:0] opc,
    output logic             legal,
    output logic [OPS_W-1:0] ops
);

    always_comb begin
        legal = 1'b1;
        ops   = '0;
        case (opc)
            OPC_W'(OPC_ADDI): ops = OPS_W'(OPS_ADD);
            OPC_W'(OPC_ANDI): ops = OPS_W'(OPS_AND);
            OPC_W'(OPC_ORI):  ops = OPS_W'(OPS_OR);
            default:          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/imm_alu_seq.sv
// rtl/imm_alu_seq.sv - hardwired T0..T5 control sequencer for addi/andi/ori
//
// Ports:
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-low reset
//   start      in   begin an instruction (honoured in IDLE only)
//   cont       in   continuous mode, sampled at the end of T5
//   mem_ready  in   memory data valid, sampled in T1 only
//   ir         in   instruction register, opcode in ir[31 -: OPC_W]
//   PCout..IRin, gra, grb, rin, rout, RYin, Cout  out  datapath strobes
//   ops        out  ALU operation code, driven in T4 only
//   busy       out  sequencing an instruction (not IDLE/DONE/FAULT)
//   done       out  instruction complete pulse
//   fault      out  memory timeout or illegal opcode, held until clear

module imm_alu_seq
    import imm_alu_pkg::*;
#(
    parameter int OPC_W    = 5,
    parameter int OPS_W    = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             cont,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             RZin,
    output logic             RZLOout,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             gra,
    output logic             grb,
    output logic             rin,
    output logic             rout,
    output logic             RYin,
    output logic             Cout,
    output logic [OPS_W-1:0] ops,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t             state_q;
    state_t             state_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic [OPS_W-1:0]   ops_q;
    logic               dec_legal;
    logic [OPS_W-1:0]   dec_ops;
    logic               wait_expired;
    logic               ir_unused;

    // Only the opcode field matters to this control unit.
    assign ir_unused = ^ir[31-OPC_W:0];

    imm_op_decode #(
        .OPC_W (OPC_W),
        .OPS_W (OPS_W)
    ) u_decode (
        .opc   (ir[31 -: OPC_W]),
        .legal (dec_legal),
        .ops   (dec_ops)
    );

    assign wait_expired = (wait_cnt == CNT_W'(WAIT_MAX));

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_nx = ST_T0;
            ST_T0:    state_nx = ST_T1;
            ST_T1: begin
                if (mem_ready)
                    state_nx = ST_T2;
                else if (wait_expired)
                    state_nx = ST_FAULT;
            end
            ST_T2:    state_nx = ST_T3;
            ST_T3:    state_nx = dec_legal ? ST_T4 : ST_FAULT;
            ST_T4:    state_nx = ST_T5;
            ST_T5:    state_nx = cont ? ST_T0 : ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            ST_FAULT: state_nx = ST_FAULT;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            wait_cnt <= '0;
            ops_q    <= '0;
        end else begin
            state_q <= state_nx;
            // T0 always precedes T1, so clearing here clears on T1 entry.
            if (state_q == ST_T0)
                wait_cnt <= '0;
            else if (state_q == ST_T1 && !mem_ready && !wait_expired)
                wait_cnt <= wait_cnt + CNT_W'(1);
            // Capture ops at T3->T4 so ir may change during T4.
            if (state_q == ST_T3)
                ops_q <= dec_ops;
        end
    end

    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        RZin    = 1'b0;
        RZLOout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        gra     = 1'b0;
        grb     = 1'b0;
        rin     = 1'b0;
        rout    = 1'b0;
        RYin    = 1'b0;
        Cout    = 1'b0;
        ops     = '0;
        busy    = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
                busy  = 1'b1;
            end
            ST_T1: begin
                RZLOout = 1'b1;
                // The counter is still zero only on the first T1 cycle, so
                // the PC is loaded once regardless of how long memory stalls.
                PCin    = (wait_cnt == '0);
                Read    = 1'b1;
                MDRin   = 1'b1;
                busy    = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                busy   = 1'b1;
            end
            ST_T3: begin
                grb  = 1'b1;
                rout = 1'b1;
                RYin = 1'b1;
                busy = 1'b1;
            end
            ST_T4: begin
                Cout = 1'b1;
                RZin = 1'b1;
                ops  = ops_q;
                busy = 1'b1;
            end
            ST_T5: begin
                RZLOout = 1'b1;
                gra     = 1'b1;
                rin     = 1'b1;
                busy    = 1'b1;
                // In continuous mode there is no DONE state, so T5 signals completion.
                done    = cont;
            end
            ST_DONE:  done  = 1'b1;
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imm_alu_seq.sv
// tb/tb_imm_alu_seq.sv - self-checking bench for imm_alu_seq

module tb_imm_alu_seq;

    typedef struct {
        logic [4:0] opc;
        int         stall;
        logic [4:0] exp_ops;
        logic       legal;
    } vec_t;

    // Strobe bundle order: PCout MARin IncPC RZin RZLOout PCin Read MDRin
    //                      MDRout IRin gra grb rin rout RYin Cout
    localparam logic [15:0] S_T0  = 16'hF000;
    localparam logic [15:0] S_T1F = 16'h0F00;
    localparam logic [15:0] S_T1S = 16'h0B00;
    localparam logic [15:0] S_T2  = 16'h00C0;
    localparam logic [15:0] S_T3  = 16'h0016;
    localparam logic [15:0] S_T4  = 16'h1001;
    localparam logic [15:0] S_T5  = 16'h0828;
    localparam logic [15:0] S_0   = 16'h0000;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin;
    logic        MDRout, IRin, gra, grb, rin, rout, RYin, Cout;
    logic [4:0]  ops;
    logic        busy, done, fault;
    logic [15:0] strb;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[7];

    always #5 clock = ~clock;

    assign strb = {PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin,
                   MDRout, IRin, gra, grb, rin, rout, RYin, Cout};

    imm_alu_seq #(
        .OPC_W    (5),
        .OPS_W    (5),
        .WAIT_MAX (15)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .cont      (cont),
        .mem_ready (mem_ready),
        .ir        (ir),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .RZin      (RZin),
        .RZLOout   (RZLOout),
        .PCin      (PCin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .gra       (gra),
        .grb       (grb),
        .rin       (rin),
        .rout      (rout),
        .RYin      (RYin),
        .Cout      (Cout),
        .ops       (ops),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] es, input logic [4:0] eo,
                         input logic eb, input logic ed, input logic ef);
        logic [23:0] act;
        logic [23:0] exp;
        #1;
        act = {strb, ops, busy, done, fault};
        exp = {es, eo, eb, ed, ef};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got strb=%h ops=%b busy=%b done=%b fault=%b, want strb=%h ops=%b busy=%b done=%b fault=%b",
                     name, strb, ops, busy, done, fault, es, eo, eb, ed, ef);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Runs one instruction from IDLE; returns in IDLE.
    task automatic run_vec(input vec_t v);
        int lat;
        ir = {v.opc, 27'h0123456};
        start = 1'b1;
        cont = 1'b0;
        mem_ready = 1'b0;
        check("idle", S_0, 5'd0, 0, 0, 0);
        tick; lat = 1;
        start = 1'b0;
        check("t0", S_T0, 5'd0, 1, 0, 0);
        tick; lat++;
        for (int i = 0; i <= v.stall; i++) begin
            mem_ready = (i == v.stall);
            check((i == 0) ? "t1_first" : "t1_stall", (i == 0) ? S_T1F : S_T1S, 5'd0, 1, 0, 0);
            tick; lat++;
        end
        mem_ready = 1'b0;
        check("t2", S_T2, 5'd0, 1, 0, 0);
        tick; lat++;
        check("t3", S_T3, 5'd0, 1, 0, 0);
        tick; lat++;
        if (!v.legal) begin
            start = 1'b1;
            check("illegal_fault", S_0, 5'd0, 0, 0, 1);
            tick;
            start = 1'b0;
            check("illegal_hold", S_0, 5'd0, 0, 0, 1);
            clear = 1'b0;
            #2;
            clear = 1'b1;
            tick;
            check("illegal_cleared", S_0, 5'd0, 0, 0, 0);
            return;
        end
        // Opcode change during T4 must not disturb the captured ops.
        ir = {(v.opc == 5'b01000) ? 5'b01010 : 5'b01000, 27'h7654321};
        check("t4", S_T4, v.exp_ops, 1, 0, 0);
        tick; lat++;
        check("t5", S_T5, 5'd0, 1, 0, 0);
        tick; lat++;
        start = 1'b1;
        check("done", S_0, 5'd0, 0, 1, 0);
        check_int("latency", lat, 7 + v.stall);
        tick;
        start = 1'b0;
        check("idle_after", S_0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{5'b01000, 0, 5'b00011, 1'b1};
        vecs[1] = '{5'b01001, 0, 5'b01010, 1'b1};
        vecs[2] = '{5'b01010, 3, 5'b01011, 1'b1};
        vecs[3] = '{5'b01000, 1, 5'b00011, 1'b1};
        vecs[4] = '{5'b11111, 0, 5'b00000, 1'b0};
        vecs[5] = '{5'b00000, 2, 5'b00000, 1'b0};
        vecs[6] = '{5'b01011, 0, 5'b00000, 1'b0};

        // Reset
        #1 clear = 1'b0;
        check("reset", S_0, 5'd0, 0, 0, 0);
        tick;
        check("reset_held", S_0, 5'd0, 0, 0, 0);
        clear = 1'b1;
        tick;
        check("idle_start", S_0, 5'd0, 0, 0, 0);

        // Table-driven instructions
        for (int k = 0; k < 7; k++)
            run_vec(vecs[k]);

        // Memory timeout: 15 stalls tolerated, fault on the 16th T1 cycle
        ir = {5'b01000, 27'h0};
        start = 1'b1;
        mem_ready = 1'b0;
        check("to_idle", S_0, 5'd0, 0, 0, 0);
        tick;
        start = 1'b0;
        check("to_t0", S_T0, 5'd0, 1, 0, 0);
        tick;
        for (int i = 0; i <= 15; i++) begin
            check((i == 0) ? "to_t1_first" : "to_t1_stall", (i == 0) ? S_T1F : S_T1S, 5'd0, 1, 0, 0);
            tick;
        end
        check("to_fault", S_0, 5'd0, 0, 0, 1);
        start = 1'b1;
        mem_ready = 1'b1;
        tick;
        check("to_start_ignored", S_0, 5'd0, 0, 0, 1);
        tick;
        check("to_start_ignored2", S_0, 5'd0, 0, 0, 1);
        start = 1'b0;
        mem_ready = 1'b0;
        clear = 1'b0;
        check("to_clear", S_0, 5'd0, 0, 0, 0);
        clear = 1'b1;
        tick;
        check("to_idle_after", S_0, 5'd0, 0, 0, 0);

        // Continuous mode: ANDI then ADDI back to back
        begin
            int cyc;
            ir = {5'b01001, 27'h0};
            cont = 1'b1;
            mem_ready = 1'b1;
            start = 1'b1;
            check("c_idle", S_0, 5'd0, 0, 0, 0);
            tick; cyc = 1;
            start = 1'b0;
            check("c1_t0", S_T0, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c1_t1", S_T1F, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c1_t2", S_T2, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c1_t3", S_T3, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c1_t4", S_T4, 5'b01010, 1, 0, 0);
            tick; cyc++;
            check("c1_t5", S_T5, 5'd0, 1, 1, 0);
            check_int("c1_cycles", cyc, 6);
            tick; cyc++;
            ir = {5'b01000, 27'h0};
            cont = 1'b0;
            check("c2_t0", S_T0, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c2_t1", S_T1F, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c2_t2", S_T2, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c2_t3", S_T3, 5'd0, 1, 0, 0);
            tick; cyc++;
            check("c2_t4", S_T4, 5'b00011, 1, 0, 0);
            tick; cyc++;
            check("c2_t5", S_T5, 5'd0, 1, 0, 0);
            check_int("c2_cycles", cyc, 12);
            tick;
            check("c2_done", S_0, 5'd0, 0, 1, 0);
            tick;
            check("c_idle_after", S_0, 5'd0, 0, 0, 0);
        end

        // Asynchronous reset in the middle of T4
        ir = {5'b01000, 27'h0};
        mem_ready = 1'b1;
        start = 1'b1;
        check("r_idle", S_0, 5'd0, 0, 0, 0);
        tick;
        start = 1'b0;
        check("r_t0", S_T0, 5'd0, 1, 0, 0);
        tick;
        check("r_t1", S_T1F, 5'd0, 1, 0, 0);
        tick;
        check("r_t2", S_T2, 5'd0, 1, 0, 0);
        tick;
        check("r_t3", S_T3, 5'd0, 1, 0, 0);
        tick;
        check("r_t4", S_T4, 5'b00011, 1, 0, 0);
        clear = 1'b0;
        check("r_async_zero", S_0, 5'd0, 0, 0, 0);
        tick;
        check("r_held", S_0, 5'd0, 0, 0, 0);
        clear = 1'b1;
        tick;
        check("r_idle_after", S_0, 5'd0, 0, 0, 0);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_alu_seq.md
# imm_alu_seq

Hardwired control sequencer for immediate-format ALU instructions (addi, andi, ori) in the DataPath. It drives the per-step control strobes that T0..T5 fetch/execute sequencing requires, as real RTL. Compared with the fixed six-step sequence, it adds:

- a memory-ready wait in the fetch step, with a timeout;
- opcode decode to the ALU `ops` code, with an illegal-opcode fault;
- a start/done handshake;
- back-to-back continuous execution.

## Interface
Parameters:
- OPC_W, 5, opcode field width, taken from ir[31 -: OPC_W]
- OPS_W, 5, width of the ALU `ops` output
- WAIT_MAX, 15, maximum cycles spent in T1 waiting for mem_ready before fault; minimum 1

Ports:
- clock  in  1  single clock, rising-edge
- clear  in  1  reset, asynchronous, active-low
- start  in  1  begin an instruction; sampled in IDLE only
- cont  in  1  continuous mode; sampled at end of T5
- mem_ready  in  1  memory data valid for MDR capture
- ir  in  32  instruction register contents (valid from T3 onward)
- PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin, MDRout, IRin  out  1 each  datapath strobes
- gra, grb, rin, rout, RYin, Cout  out  1 each  register-select and operand strobes
- ops  out  OPS_W  ALU operation code
- busy  out  1  high in any state other than IDLE, DONE and FAULT
- done  out  1  one-cycle pulse on the instruction-complete state
- fault  out  1  high while in FAULT

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, DONE, FAULT.
- Outputs are a Moore decode of the state register. All strobes are 0 and ops = 0 outside their listed step.
- IDLE: start=1 -> T0.
- T0: PCout, MARin, IncPC, RZin -> T1.
- T1: RZLOout, PCin, Read, MDRin.
  - Stays in T1 while mem_ready=0; a wait counter increments each stalled cycle.
  - PCin is asserted on the first T1 cycle only; later cycles hold the other three strobes.
  - mem_ready=1 -> T2.
  - Counter reaching WAIT_MAX with mem_ready=0 -> FAULT.
- T2: MDRout, IRin -> T3.
- T3: grb, rout, RYin.
  - Opcode decode happens here: legal -> T4; illegal -> FAULT. No register write occurs on an illegal opcode.
- T4: Cout, RZin, ops = decoded code -> T5.
- T5: RZLOout, gra, rin -> DONE.
  - Exception: if cont=1, go to T0 and pulse done for this cycle instead.
- DONE: done=1 -> IDLE.
- FAULT: fault=1, held until clear.
- Decode:
  - ADDI (5'b01000) -> ops 5'b00011
  - ANDI (5'b01001) -> ops 5'b01010
  - ORI (5'b01010) -> ops 5'b01011
  - any other opcode is illegal.

## Timing
- Reset (clear=0, asynchronous): state = IDLE, wait counter = 0, every output 0. Reset takes effect mid-instruction from any state. No strobe may remain high after clear falls.
- Latency from start=1 in IDLE to done:
  - 7 cycles with mem_ready already high in T1;
  - +1 cycle per stalled T1 cycle.
- Continuous mode: done pulses in T5. Next T0 follows T5 immediately, so each instruction takes 6 cycles.
- start is ignored while busy, in DONE, or in FAULT.
- mem_ready is only sampled in T1.
- The wait counter clears on entry to T1.
- WAIT_MAX stalled cycles are tolerated. Fault is taken on the cycle the count equals WAIT_MAX.
- ir is sampled combinationally in T3 and T4. The decoded ops is registered at the T3->T4 edge, so ir changes during T4 do not alter ops.
- At most one state transition per cycle. FAULT has priority over the cont path.

## Structure
- Package imm_alu_pkg holds:
  - state enum;
  - opcode constants OPC_ADDI, OPC_ANDI, OPC_ORI;
  - ALU codes OPS_ADD = 5'b00011, OPS_AND = 5'b01010, OPS_OR = 5'b01011.
- One sub-module, imm_op_decode: purely combinational; maps opcode to {legal, ops}. It is reused by later control units for register-format ops.
- FSM, wait counter and output decode live in the top module.

## Test plan
- ADDI, mem_ready tied high: ir[31:27] = 01000, start pulse.
  - Strobe sequence follows T0..T5 exactly.
  - ops = 00011 during T4 only.
  - done rises 7 cycles after start; busy is low afterwards.
- ORI with 3-cycle memory stall: mem_ready low for 3 T1 cycles.
  - Read and MDRin held 4 cycles; PCin high only on the first.
  - ops = 01011; done at cycle 10.
- Timeout: mem_ready held 0, WAIT_MAX = 15.
  - FAULT is entered after 15 stalled cycles; all strobes go 0.
  - start is ignored thereafter; clear returns to IDLE.
- Illegal opcode 5'b11111: FAULT entered after T3.
  - Cout, RZin, gra and rin are never asserted.
- Continuous mode: cont=1 with ANDI then ADDI.
  - T0 directly follows T5; done pulses in each T5.
  - ops = 01010, then 00011; 12 cycles total.
- Reset mid-T4: clear low asynchronously.
  - All outputs 0 immediately, before the next clock edge.
  - After release, the state is IDLE and a new start runs normally.
